kronos_md_seq: RTL and testbench

- Multi-cycle sequencer for RV32M-subset operations MUL, DIVU and REMU.
- Owns no adder. Each add, subtract and unsigned compare is issued to the core's shared kronos_alu instance through a request/grant port, and the block holds the iteration state between steps.
- Sits beside the execute stage. The decoder hands it operands over a valid/ready request; the block returns a 32-bit result over a valid/ready response.

---
 rtl/kronos_md_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_kronos_md_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_md_seq.sv
// kronos_md_seq: multi-cycle MUL / DIVU / REMU sequencer.
// Has no adder of its own. Every add, subtract and compare goes through the
// core's shared ALU over a request/grant port; this block only keeps the
// iteration state between steps.
module kronos_md_seq #(
  parameter bit MUL_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        kill,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_aluop,
  input  logic [31:0] alu_result
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL  = 3'd1;
  localparam logic [2:0] DCMP = 3'd2;
  localparam logic [2:0] DSUB = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // Encodings of the shared ALU's operation select.
  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b1000;
  localparam logic [3:0] SLTU = 4'b0011;

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] divisor_q, divisor_d;
  logic        hibit_q, hibit_d;
  logic        is_rem_q, is_rem_d;
  logic [31:0] result_q, result_d;

  logic        mul_alu;
  logic        iter_end;
  logic        ge;
  logic [31:0] acc_t, rem_t, quo_t;

  // With skipping enabled, only steps that actually add need the ALU.
  assign mul_alu = !MUL_SKIP || mplier_q[0];

  // Handshake outputs; a kill cycle neither accepts nor offers a result.
  always_comb begin
    req_ready = (state_q == IDLE) && !kill;
    rsp_valid = (state_q == DONE) && !kill;
    rsp_data  = result_q;
  end

  // ALU request and operands, driven from registered state only so they
  // hold still across ungranted cycles.
  always_comb begin
    alu_req   = 1'b0;
    alu_op1   = 32'd0;
    alu_op2   = 32'd0;
    alu_aluop = ADD;
    if (!kill) begin
      case (state_q)
        MUL: begin
          if (mul_alu) begin
            alu_req = 1'b1;
            alu_op1 = acc_q;
            alu_op2 = mcand_q;
          end
        end
        DCMP: begin
          alu_req   = 1'b1;
          alu_op1   = rem_q;
          alu_op2   = divisor_q;
          alu_aluop = SLTU;
        end
        DSUB: begin
          alu_req   = 1'b1;
          alu_op1   = rem_q;
          alu_op2   = divisor_q;
          alu_aluop = SUB;
        end
        default: ;
      endcase
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    hibit_d   = hibit_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;
    iter_end  = 1'b0;
    ge        = hibit_q | ~alu_result[0];
    acc_t     = mplier_q[0] ? alu_result : acc_q;
    rem_t     = rem_q;
    quo_t     = quo_q;

    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cnt_d    = 5'd0;
            is_rem_d = (req_op == 2'b11);
            if (!req_op[1]) begin
              state_d  = MUL;
              acc_d    = 32'd0;
              mcand_d  = req_op1;
              mplier_d = req_op2;
            end else if (req_op2 == 32'd0) begin
              state_d  = DONE;
              result_d = req_op[0] ? req_op1 : 32'hFFFF_FFFF;
            end else begin
              // First iteration shift folded into the accept.
              state_d   = DCMP;
              divisor_d = req_op2;
              hibit_d   = 1'b0;
              rem_d     = {31'd0, req_op1[31]};
              quo_d     = {req_op1[30:0], 1'b0};
            end
          end
        end
        MUL: begin
          if (MUL_SKIP && (mplier_q == 32'd0)) begin
            state_d  = DONE;
            result_d = acc_q;
          end else if (alu_gnt || !mul_alu) begin
            acc_d    = acc_t;
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + 5'd1;
            if ((cnt_q == 5'd31) || (MUL_SKIP && (mplier_q[31:1] == 31'd0))) begin
              state_d  = DONE;
              result_d = acc_t;
            end
          end
        end
        DCMP: begin
          if (alu_gnt) begin
            if (ge) state_d = DSUB;
            else    iter_end = 1'b1;
          end
        end
        DSUB: begin
          if (alu_gnt) begin
            // Shifted remainder is below twice the divisor, so 32 bits suffice.
            rem_t    = alu_result;
            quo_t    = {quo_q[31:1], 1'b1};
            iter_end = 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (iter_end) begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = DONE;
          rem_d    = rem_t;
          quo_d    = quo_t;
          result_d = is_rem_q ? rem_t : quo_t;
        end else begin
          state_d          = DCMP;
          {hibit_d, rem_d} = {rem_t, quo_t[31]};
          quo_d            = {quo_t[30:0], 1'b0};
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 32'd0;
      mcand_q   <= 32'd0;
      mplier_q  <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      divisor_q <= 32'd0;
      hibit_q   <= 1'b0;
      is_rem_q  <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      hibit_q   <= hibit_d;
      is_rem_q  <= is_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_kronos_md_seq.sv
// Directed bench for kronos_md_seq: one instance without MUL skipping, one
// with. Each has its own ALU model; stimulus is shared except req_valid.
module tb_kronos_md_seq;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic        kill = 1'b0;
  logic        rsp_ready = 1'b1;
  logic        alu_gnt = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_op1 = 32'd0;
  logic [31:0] req_op2 = 32'd0;

  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        alu_req [2];
  logic [31:0] rsp_data [2];
  logic [31:0] alu_op1 [2];
  logic [31:0] alu_op2 [2];
  logic [31:0] alu_result [2];
  logic [3:0]  alu_aluop [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0011: return {31'd0, a < b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result[0] = alu_f(alu_aluop[0], alu_op1[0], alu_op2[0]);
  assign alu_result[1] = alu_f(alu_aluop[1], alu_op1[1], alu_op2[1]);

  kronos_md_seq #(.MUL_SKIP(1'b0)) dut0 (
    .clk(clk), .rstz(rstz), .kill(kill),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
    .alu_req(alu_req[0]), .alu_gnt(alu_gnt), .alu_op1(alu_op1[0]), .alu_op2(alu_op2[0]),
    .alu_aluop(alu_aluop[0]), .alu_result(alu_result[0])
  );

  kronos_md_seq #(.MUL_SKIP(1'b1)) dut1 (
    .clk(clk), .rstz(rstz), .kill(kill),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
    .alu_req(alu_req[1]), .alu_gnt(alu_gnt), .alu_op1(alu_op1[1]), .alu_op2(alu_op2[1]),
    .alu_aluop(alu_aluop[1]), .alu_result(alu_result[1])
  );

  typedef struct {
    string       nm;
    int          sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          tog;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_grants;
  } vec_t;

  function automatic vec_t mk(input string nm, input int sel, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b, input bit tog,
                              input logic [31:0] d, input int lat, input int g);
    vec_t v;
    v.nm = nm; v.sel = sel; v.op = op; v.a = a; v.b = b; v.tog = tog;
    v.exp_data = d; v.exp_lat = lat; v.exp_grants = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle. Returns the cycle (after the
  // accept edge) in which rsp_valid is first seen, granted ALU cycles, and how
  // many stalled cycles saw the ALU request or operands move.
  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit tog, output int lat,
                        output int grants, output int unstable, output logic [31:0] data);
    logic [31:0] p1, p2;
    logic [3:0]  pop;
    bit          stall;
    req_op = op; req_op1 = a; req_op2 = b; req_valid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[sel] = 1'b0;
    lat = 1; grants = 0; unstable = 0;
    while (!rsp_valid[sel] && lat < 300) begin
      if (tog) alu_gnt = (lat % 2 == 0);
      #1;
      if (alu_req[sel] && alu_gnt) grants++;
      stall = alu_req[sel] && !alu_gnt;
      p1 = alu_op1[sel]; p2 = alu_op2[sel]; pop = alu_aluop[sel];
      @(negedge clk);
      lat++;
      if (stall && (!alu_req[sel] || alu_op1[sel] !== p1 || alu_op2[sel] !== p2 ||
                    alu_aluop[sel] !== pop))
        unstable++;
    end
    alu_gnt = 1'b1;
    data = rsp_data[sel];
    if (!rsp_valid[sel]) begin
      // Timed out: flush so later tests start clean.
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
    end else if (rsp_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t        vecs[13];
    int          lat, grants, unstable, seen;
    logic [31:0] data;

    vecs[0]  = mk("mul_1234x5678",  0, 2'b00, 32'h1234, 32'h5678, 0, 32'h0626_0060, 33, 32);
    vecs[1]  = mk("mulskip_m1x3",   1, 2'b00, 32'hFFFF_FFFF, 32'd3, 0, 32'hFFFF_FFFD, 3, 2);
    vecs[2]  = mk("divu_100_7",     0, 2'b10, 32'd100, 32'd7, 0, 32'd14, 36, 35);
    vecs[3]  = mk("remu_100_7",     0, 2'b11, 32'd100, 32'd7, 0, 32'd2, 36, 35);
    vecs[4]  = mk("divu_big",       0, 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0, 32'd1, 34, 33);
    vecs[5]  = mk("remu_big",       0, 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0,
                  32'h7FFF_FFFE, 34, 33);
    vecs[6]  = mk("divu_by0",       0, 2'b10, 32'h1234, 32'd0, 0, 32'hFFFF_FFFF, 1, 0);
    vecs[7]  = mk("remu_5_by0",     0, 2'b11, 32'd5, 32'd0, 0, 32'd5, 1, 0);
    vecs[8]  = mk("divu_toggle",    0, 2'b10, 32'd100, 32'd7, 1, 32'd14, 71, 35);
    vecs[9]  = mk("mul_alias_m1sq", 0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd1, 33, 32);
    vecs[10] = mk("mulskip_3x5",    1, 2'b00, 32'd3, 32'd5, 0, 32'd15, 4, 2);
    vecs[11] = mk("mulskip_x0",     1, 2'b00, 32'h1234, 32'd0, 0, 32'd0, 2, 0);
    vecs[12] = mk("skipdut_divu",   1, 2'b10, 32'd100, 32'd7, 0, 32'd14, 36, 35);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_rsp_valid%0d", s), rsp_valid[s], 0);
      chk($sformatf("rst_rsp_data%0d", s), rsp_data[s], 0);
      chk($sformatf("rst_alu_req%0d", s), alu_req[s], 0);
    end
    chk("rst_alu_op1", alu_op1[0], 0);
    chk("rst_alu_op2", alu_op2[0], 0);
    chk("rst_alu_aluop", alu_aluop[0], 0);
    @(negedge clk);
    rstz = 1'b1;
    #1;
    chk("rst_req_ready0", req_ready[0], 1);
    chk("rst_req_ready1", req_ready[1], 1);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tog,
             lat, grants, unstable, data);
      chk({vecs[i].nm, "_data"}, data, vecs[i].exp_data);
      chk({vecs[i].nm, "_lat"}, lat, vecs[i].exp_lat);
      chk({vecs[i].nm, "_grants"}, grants, vecs[i].exp_grants);
      if (vecs[i].tog) chk({vecs[i].nm, "_stall_hold"}, unstable, 0);
    end

    // Kill in the middle of a MUL.
    req_op = 2'b00; req_op1 = 32'h1234; req_op2 = 32'h5678; req_valid[0] = 1'b1;
    #1;
    chk("kill_pre_ready", req_ready[0], 1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("kill_busy_alu_req", alu_req[0], 1);
    kill = 1'b1;
    #1;
    chk("kill_alu_req_drop", alu_req[0], 0);
    chk("kill_req_ready_low", req_ready[0], 0);
    chk("kill_rsp_valid", rsp_valid[0], 0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("kill_idle_ready", req_ready[0], 1);
    chk("kill_idle_alu_req", alu_req[0], 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    chk("kill_no_rsp", seen, 0);
    run_op(0, 2'b00, 32'd3, 32'd5, 0, lat, grants, unstable, data);
    chk("post_kill_mul_data", data, 32'd15);
    chk("post_kill_mul_lat", lat, 33);

    // Response held while the consumer stalls.
    rsp_ready = 1'b0;
    run_op(0, 2'b10, 32'd100, 32'd7, 0, lat, grants, unstable, data);
    chk("hold_data", data, 32'd14);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_valid_%0d", k), rsp_valid[0], 1);
      chk($sformatf("hold_rsp_data_%0d", k), rsp_data[0], 32'd14);
      chk($sformatf("hold_req_ready_%0d", k), req_ready[0], 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release_valid", rsp_valid[0], 0);
    chk("hold_release_ready", req_ready[0], 1);

    // Asynchronous reset in the middle of a divide.
    req_op = 2'b10; req_op1 = 32'd100; req_op2 = 32'd7; req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rstz = 1'b0;
    #1;
    chk("arst_alu_req", alu_req[0], 0);
    chk("arst_rsp_valid", rsp_valid[0], 0);
    chk("arst_rsp_data", rsp_data[0], 0);
    @(negedge clk);
    rstz = 1'b1;
    #1;
    chk("arst_req_ready", req_ready[0], 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid[0]) seen++;
    end
    chk("arst_no_rsp", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
